// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, reads one ROM word per cycle into a
// small prefetch queue and hands {pc, instr} pairs to decode; redirects flush it.
module fetch_unit #(
  parameter int          ADDRESS_WIDTH = 32,
  parameter int unsigned ROM_BYTES     = 4096,
  parameter int unsigned RESET_PC      = 0,
  parameter int unsigned DEPTH         = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] rom_pc,
  input  logic [31:0]              rom_instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [31:0]              out_instr,
  output logic                     misalign
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [ADDRESS_WIDTH-1:0] WRAP_MASK = ADDRESS_WIDTH'(ROM_BYTES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] TGT_MASK  = WRAP_MASK & ~ADDRESS_WIDTH'(3);
  localparam logic [ADDRESS_WIDTH-1:0] PC_RST    = ADDRESS_WIDTH'(RESET_PC);

  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         count_q, count_d;
  logic                     misalign_q, misalign_d;
  logic [ADDRESS_WIDTH-1:0] mem_pc_q    [DEPTH];
  logic [ADDRESS_WIDTH-1:0] mem_pc_d    [DEPTH];
  logic [31:0]              mem_instr_q [DEPTH];
  logic [31:0]              mem_instr_d [DEPTH];
  logic                     deq, enq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rom_pc    = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = mem_pc_q[rd_ptr_q[IDX_W-1:0]];
  assign out_instr = mem_instr_q[rd_ptr_q[IDX_W-1:0]];
  assign misalign  = misalign_q;

  always_comb begin
    deq         = out_valid & out_ready;
    // Room exists if not full, or if the head leaves this same cycle.
    enq         = !redirect_valid & ((count_q < PTR_W'(DEPTH)) | deq);
    fetch_pc_d  = fetch_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    misalign_d  = misalign_q;
    mem_pc_d    = mem_pc_q;
    mem_instr_d = mem_instr_q;
    if (redirect_valid) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc & TGT_MASK;
      if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
    end else begin
      if (enq) begin
        mem_pc_d[wr_ptr_q[IDX_W-1:0]]    = fetch_pc_q;
        mem_instr_d[wr_ptr_q[IDX_W-1:0]] = rom_instr;
        wr_ptr_d   = ptr_inc(wr_ptr_q);
        fetch_pc_d = (fetch_pc_q + ADDRESS_WIDTH'(4)) & WRAP_MASK;
      end
      if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({enq, deq})
        2'b10:   count_d = count_q + PTR_W'(1);
        2'b01:   count_d = count_q - PTR_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= PC_RST;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      misalign_q  <= misalign_d;
      mem_pc_q    <= mem_pc_d;
      mem_instr_q <= mem_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, plus
// directed literal checks for reset, backpressure, redirect, wrap and misalign.
module tb_fetch_unit;

  localparam int ROMB = 4096;

  logic        clk;
  logic        rst;
  logic [31:0] rom_pc;
  logic [31:0] rom_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        misalign;

  fetch_unit #(.ADDRESS_WIDTH(32), .ROM_BYTES(ROMB), .RESET_PC(0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rom_pc(rom_pc), .rom_instr(rom_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .misalign(misalign)
  );

  logic [7:0] rom_b [ROMB];

  function automatic logic [31:0] romword(input logic [31:0] a);
    int unsigned base;
    base = a & (ROMB - 4);
    return {rom_b[base+3], rom_b[base+2], rom_b[base+1], rom_b[base]};
  endfunction

  always_comb rom_instr = romword(rom_pc);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] mq[$];
  logic [31:0] mfpc = 32'h0;
  logic        mmis = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    check("rom_pc", rom_pc, mfpc);
    check("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      check("out_pc", out_pc, mq[0][63:32]);
      check("out_instr", out_instr, mq[0][31:0]);
    end
    check("misalign", {31'b0, misalign}, {31'b0, mmis});
  endtask

  // Spec-level behaviour: pop if accepted, then either flush on redirect or
  // fetch the next word when there is room after the pop.
  task automatic model_step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    if (r) begin
      mq.delete();
      mfpc = 32'h0;
      mmis = 1'b0;
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (rv) begin
        mq.delete();
        mfpc = rpc & (ROMB - 1) & ~32'h3;
        if (rpc[1:0] != 2'b00) mmis = 1'b1;
      end else if (mq.size() < 2) begin
        mq.push_back({mfpc, romword(mfpc)});
        mfpc = (mfpc + 4) % ROMB;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    #3;
    compare();
    model_step(r, rv, rpc, rdy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < ROMB; i++) rom_b[i] = 8'($urandom);
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset and stream
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_rom_pc", rom_pc, 32'h0);
    check("rst_misalign", {31'b0, misalign}, 32'h0);
    cycle(0, 0, 0, 1);
    check("s0_pc", out_pc, 32'h000);
    check("s0_instr", out_instr, {rom_b[3], rom_b[2], rom_b[1], rom_b[0]});
    cycle(0, 0, 0, 1);
    check("s1_pc", out_pc, 32'h004);
    check("s1_instr", out_instr, {rom_b[7], rom_b[6], rom_b[5], rom_b[4]});
    cycle(0, 0, 0, 1);
    check("s2_pc", out_pc, 32'h008);

    // Backpressure from a fresh reset
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
    check("bp_rom_pc", rom_pc, 32'h008);
    check("bp_head", out_pc, 32'h000);
    cycle(0, 0, 0, 1);
    check("bp_r1", out_pc, 32'h004);
    cycle(0, 0, 0, 1);
    check("bp_r2", out_pc, 32'h008);
    check("bp_r2_valid", {31'b0, out_valid}, 32'h1);

    // Redirect flush with a full queue and a simultaneous dequeue
    cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h100, 1);
    check("rd_valid0", {31'b0, out_valid}, 32'h0);
    check("rd_rom_pc", rom_pc, 32'h100);
    cycle(0, 0, 0, 1);
    check("rd_pc", out_pc, 32'h100);

    // Wrap-around
    cycle(0, 1, 32'hFF8, 1);
    cycle(0, 0, 0, 1);
    check("wr0", out_pc, 32'hFF8);
    cycle(0, 0, 0, 1);
    check("wr1", out_pc, 32'hFFC);
    cycle(0, 0, 0, 1);
    check("wr2", out_pc, 32'h000);
    cycle(0, 0, 0, 1);
    check("wr3", out_pc, 32'h004);

    // Misaligned redirect, sticky across later redirects
    cycle(0, 1, 32'h10E, 1);
    check("mis_rom_pc", rom_pc, 32'h10C);
    check("mis_flag", {31'b0, misalign}, 32'h1);
    cycle(0, 0, 0, 1);
    check("mis_pc", out_pc, 32'h10C);
    cycle(0, 1, 32'h200, 1);
    cycle(0, 0, 0, 1);
    check("mis_sticky", {31'b0, misalign}, 32'h1);

    // Reset mid-operation: two entries queued, fetch_pc = 0x040
    cycle(0, 1, 32'h038, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("mid_rom_pc", rom_pc, 32'h040);
    cycle(1, 0, 0, 1);
    check("mid_valid", {31'b0, out_valid}, 32'h0);
    check("mid_mis", {31'b0, misalign}, 32'h0);
    cycle(0, 0, 0, 1);
    check("mid_restart", out_pc, 32'h000);

    // Randomized traffic including back-to-back redirects and resets
    for (int i = 0; i < 3000; i++) begin
      logic        r, rv, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(99) == 0);
      rv  = ($urandom_range(9) == 0);
      rdy = ($urandom_range(9) < 7);
      rpc = $urandom;
      cycle(r, rv, rpc, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
